// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with registered occupancy and flags,
// selectable standard (registered) or first-word-fall-through read, and
// sticky overflow/underflow error flags.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   winc, wdata      write request and data
//   wfull            count == DEPTH
//   walmost_full     count >= AFULL_THR
//   rinc, rdata      read request and data (1-cycle latency, or FWFT)
//   rempty           count == 0
//   ralmost_empty    count <= AEMPTY_THR
//   count            occupancy 0..DEPTH
//   wovf, rudf       sticky: write while full / read while empty
module sync_fifo_buf #(
  parameter int unsigned DATALEN    = 8,
  parameter int unsigned ADDRLEN    = 4,
  parameter int unsigned AFULL_THR  = 6,
  parameter int unsigned AEMPTY_THR = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               winc,
  input  logic [DATALEN-1:0] wdata,
  output logic               wfull,
  output logic               walmost_full,
  input  logic               rinc,
  output logic [DATALEN-1:0] rdata,
  output logic               rempty,
  output logic               ralmost_empty,
  output logic [ADDRLEN-1:0] count,
  output logic               wovf,
  output logic               rudf
);

  localparam int unsigned AW    = ADDRLEN - 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DATALEN-1:0] mem [DEPTH];

  logic [ADDRLEN-1:0] wptr, rptr;
  logic [ADDRLEN-1:0] wptr_nxt, rptr_nxt, count_nxt;
  logic               wr_en, rd_en;
  logic               full_nxt, empty_nxt;

  // Acceptance uses only registered flags, so no input-to-flag path exists.
  always_comb begin
    wr_en     = winc && !wfull;
    rd_en     = rinc && !rempty;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    if (wr_en) wptr_nxt = wptr + ADDRLEN'(1);
    if (rd_en) rptr_nxt = rptr + ADDRLEN'(1);
    count_nxt = wptr_nxt - rptr_nxt;
    full_nxt  = (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
    empty_nxt = (wptr_nxt == rptr_nxt);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      wovf          <= 1'b0;
      rudf          <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      wfull         <= full_nxt;
      rempty        <= empty_nxt;
      walmost_full  <= (count_nxt >= ADDRLEN'(AFULL_THR));
      ralmost_empty <= (count_nxt <= ADDRLEN'(AEMPTY_THR));
      if (winc && wfull)  wovf <= 1'b1;
      if (rinc && rempty) rudf <= 1'b1;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty for a clean value.
      assign rdata = rempty ? '0 : mem[rptr[AW-1:0]];
    end else begin : g_std
      logic [DATALEN-1:0] rdata_q;

      // Registered read, holds when no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rptr[AW-1:0]];
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: a standard-read and an FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic       wfull, walmost_full, rempty, ralmost_empty, wovf, rudf;
  logic [7:0] rdata;
  logic [3:0] count;

  logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_wovf, f_rudf;
  logic [7:0] f_rdata;
  logic [3:0] f_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] q[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo_buf #(.DATALEN(8), .ADDRLEN(4), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .wovf(wovf), .rudf(rudf)
  );

  sync_fifo_buf #(.DATALEN(8), .ADDRLEN(4), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(f_wfull),
    .walmost_full(f_walmost_full), .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_ralmost_empty), .count(f_count), .wovf(f_wovf), .rudf(f_rudf)
  );

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = 8'h00;
  endtask

  // FIFO semantics: reject write when full, reject read when empty.
  task automatic model_step(input logic w, input logic r, input logic [7:0] d);
    bit was_full, was_empty;
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    if (r && !was_empty) m_rd = q.pop_front();
    if (w && !was_full)  q.push_back(d);
  endtask

  // One clock with the given request; returns 1 ns after the edge.
  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    model_step(w, r, d);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b want 1", rempty); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b want 0", wfull); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_raempty got %b want 1", ralmost_empty); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_wafull got %b want 0", walmost_full); end
    checks++; if ({wovf, rudf} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {wovf, rudf}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'h11 * i));
      checks++;
      if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      checks++;
      if ({wfull, walmost_full} !== {i == 8, i >= 6}) begin
        errors++; $display("FAIL fill_flags[%0d] got %b want %b", i, {wfull, walmost_full}, {i == 8, i >= 6});
      end
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (f_rdata !== 8'(8'h11 * i)) begin errors++; $display("FAIL fwft_head[%0d] got %h want %h", i, f_rdata, 8'(8'h11 * i)); end
      drive(1'b0, 1'b1, 8'h00);
      checks++;
      if (rdata !== 8'(8'h11 * i)) begin errors++; $display("FAIL drain_rdata[%0d] got %h want %h", i, rdata, 8'(8'h11 * i)); end
    end
    checks++; if ({rempty, count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL drain_empty got %b/%0d want 1/0", rempty, count); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i));
    drive(1'b1, 1'b0, 8'hFF);
    checks++; if ({wovf, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL ovf got %b/%0d want 1/8", wovf, count); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++;
      if (rdata === 8'hFF || rdata !== m_rd) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, rdata, m_rd); end
    end
    checks++; if (rudf !== 1'b0) begin errors++; $display("FAIL udf_early got %b want 0", rudf); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if ({rudf, count, wovf} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL udf got %b/%0d/%b want 1/0/1", rudf, count, wovf); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] pat;
    logic [7:0] want;
    do_reset();
    pat  = 8'h30;
    want = 8'h30;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, pat); pat++; end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, pat);
      pat++;
      checks++;
      if (count !== 4'd3 || rdata !== want) begin
        errors++; $display("FAIL wrap[%0d] got %0d/%h want 3/%h", i, count, rdata, want);
      end
      want++;
    end
  endtask

  task automatic test_simul_empty();
    do_reset();
    drive(1'b1, 1'b1, 8'h5A);
    checks++; if ({count, rudf, rempty} !== {4'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL simul_empty got %0d/%b/%b want 1/1/0", count, rudf, rempty); end
    checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL simul_fwft got %h want 5a", f_rdata); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL simul_std_hold got %h want 00", rdata); end
  endtask

  task automatic test_random();
    logic [13:0] exp_v;
    int sz;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
      sz = q.size();
      exp_v = {sz == 8, sz >= 6, sz == 0, sz <= 2, m_ovf, m_udf, 4'(sz), 4'(sz)};
      checks++;
      if ({wfull, walmost_full, rempty, ralmost_empty, wovf, rudf, count, f_count} !== exp_v) begin
        errors++; $display("FAIL rand_state[%0d] got %b want %b", i,
          {wfull, walmost_full, rempty, ralmost_empty, wovf, rudf, count, f_count}, exp_v);
      end
      checks++;
      if (rdata !== m_rd) begin errors++; $display("FAIL rand_rdata[%0d] got %h want %h", i, rdata, m_rd); end
      if (sz != 0) begin
        checks++;
        if (f_rdata !== q[0]) begin errors++; $display("FAIL rand_fwft[%0d] got %h want %h", i, f_rdata, q[0]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h60 + i));
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h65);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d want 5", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rempty, ralmost_empty, wfull, walmost_full, wovf, rudf, count} !== {6'b110000, 4'd0}) begin
      errors++; $display("FAIL async_flags got %b want 1100000000",
        {rempty, ralmost_empty, wfull, walmost_full, wovf, rudf, count});
    end
    checks++; if ({rdata, f_rdata} !== 16'h0000) begin errors++; $display("FAIL async_rdata got %h want 0000", {rdata, f_rdata}); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 8'hC3);
    checks++; if (f_rdata !== 8'hC3) begin errors++; $display("FAIL post_reset_fwft got %h want c3", f_rdata); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if ({rdata, count, rempty} !== {8'hC3, 4'd0, 1'b1}) begin errors++; $display("FAIL post_reset_read got %h/%0d/%b want c3/0/1", rdata, count, rempty); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_back_to_back_wrap();
    test_simul_empty();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
